// File: rtl/dpram_rr_arbiter_if.sv
// Client and SRAM-side signal bundle for the two-requester dpram arbiter.
// The arbiter takes the slave view; the clients and the SRAM macro together take the master view.
interface dpram_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_req_0;
    logic                  wr_req_1;
    logic [ADDR_WIDTH-1:0] wr_addr_0;
    logic [ADDR_WIDTH-1:0] wr_addr_1;
    logic [DATA_WIDTH-1:0] wr_data_0;
    logic [DATA_WIDTH-1:0] wr_data_1;
    logic                  wr_gnt_0;
    logic                  wr_gnt_1;
    logic                  rd_req_0;
    logic                  rd_req_1;
    logic [ADDR_WIDTH-1:0] rd_addr_0;
    logic [ADDR_WIDTH-1:0] rd_addr_1;
    logic                  rd_gnt_0;
    logic                  rd_gnt_1;
    logic                  rd_valid_0;
    logic                  rd_valid_1;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  wr_req_0, wr_req_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        input  rd_req_0, rd_req_1, rd_addr_0, rd_addr_1, mem_rdata,
        output wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1, rd_valid_0, rd_valid_1, rd_data,
        output mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );

    modport master (
        output wr_req_0, wr_req_1, wr_addr_0, wr_addr_1, wr_data_0, wr_data_1,
        output rd_req_0, rd_req_1, rd_addr_0, rd_addr_1, mem_rdata,
        input  wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1, rd_valid_0, rd_valid_1, rd_data,
        input  mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter and zero-fill initialiser for a 1024x32 dual-port SRAM.
// Write and read ports are arbitrated independently so one write and one read can complete per cycle.
module dpram_rr_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_ZERO  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    dpram_rr_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic                  wr_prio_r;
    logic                  rd_prio_r;
    logic                  rd_valid_0_r;
    logic                  rd_valid_1_r;
    logic                  run_s;
    logic                  init_s;
    logic                  wr_gnt_0_s;
    logic                  wr_gnt_1_s;
    logic                  rd_gnt_0_s;
    logic                  rd_gnt_1_s;

    // Reset gates everything so the SRAM sees no enables while rst_n is low.
    assign run_s  = rst_n && (state_r == ST_RUN);
    assign init_s = rst_n && (state_r == ST_INIT);

    // Grant logic: a lone requester wins, otherwise the pointer (0 = requester 0 first) decides.
    always_comb begin
        wr_gnt_0_s = 1'b0;
        wr_gnt_1_s = 1'b0;
        rd_gnt_0_s = 1'b0;
        rd_gnt_1_s = 1'b0;
        if (run_s) begin
            wr_gnt_0_s = bus.wr_req_0 && (!bus.wr_req_1 || !wr_prio_r);
            wr_gnt_1_s = bus.wr_req_1 && (!bus.wr_req_0 ||  wr_prio_r);
            rd_gnt_0_s = bus.rd_req_0 && (!bus.rd_req_1 || !rd_prio_r);
            rd_gnt_1_s = bus.rd_req_1 && (!bus.rd_req_0 ||  rd_prio_r);
        end else begin
            wr_gnt_0_s = 1'b0;
            wr_gnt_1_s = 1'b0;
            rd_gnt_0_s = 1'b0;
            rd_gnt_1_s = 1'b0;
        end
    end

    // SRAM port muxing; idle selects requester 0 so the buses never float.
    always_comb begin
        bus.mem_wen   = wr_gnt_0_s || wr_gnt_1_s;
        bus.mem_waddr = bus.wr_addr_0;
        bus.mem_wdata = bus.wr_data_0;
        if (init_s) begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = init_cnt_r;
            bus.mem_wdata = {DATA_WIDTH{1'b0}};
        end else if (wr_gnt_1_s) begin
            bus.mem_waddr = bus.wr_addr_1;
            bus.mem_wdata = bus.wr_data_1;
        end else begin
            bus.mem_waddr = bus.wr_addr_0;
            bus.mem_wdata = bus.wr_data_0;
        end
        bus.mem_ren   = rd_gnt_0_s || rd_gnt_1_s;
        bus.mem_raddr = bus.rd_addr_0;
        if (rd_gnt_1_s) begin
            bus.mem_raddr = bus.rd_addr_1;
        end else begin
            bus.mem_raddr = bus.rd_addr_0;
        end
    end

    // Init/run sequencing, priority pointers and read-valid tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_cnt_r   <= {ADDR_WIDTH{1'b0}};
            wr_prio_r    <= 1'b0;
            rd_prio_r    <= 1'b0;
            rd_valid_0_r <= 1'b0;
            rd_valid_1_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
                    if (init_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_INIT;
                    end
                end
                ST_RUN: begin
                    if (wr_gnt_0_s) begin
                        wr_prio_r <= 1'b1;
                    end else if (wr_gnt_1_s) begin
                        wr_prio_r <= 1'b0;
                    end else begin
                        wr_prio_r <= wr_prio_r;
                    end
                    if (rd_gnt_0_s) begin
                        rd_prio_r <= 1'b1;
                    end else if (rd_gnt_1_s) begin
                        rd_prio_r <= 1'b0;
                    end else begin
                        rd_prio_r <= rd_prio_r;
                    end
                end
                default: begin
                    state_r    <= ST_INIT;
                    init_cnt_r <= {ADDR_WIDTH{1'b0}};
                end
            endcase
            rd_valid_0_r <= rd_gnt_0_s;
            rd_valid_1_r <= rd_gnt_1_s;
        end
    end

    assign init_done      = run_s;
    assign bus.wr_gnt_0   = wr_gnt_0_s;
    assign bus.wr_gnt_1   = wr_gnt_1_s;
    assign bus.rd_gnt_0   = rd_gnt_0_s;
    assign bus.rd_gnt_1   = rd_gnt_1_s;
    assign bus.rd_valid_0 = rd_valid_0_r;
    assign bus.rd_valid_1 = rd_valid_1_r;
    assign bus.rd_data    = bus.mem_rdata;
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed bench for dpram_rr_arbiter with a behavioural read-before-write SRAM
// and a queue of expected read returns.
module tb_dpram_rr_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        bit          who;
        logic [31:0] data;
    } rd_exp_t;

    logic clk;
    logic rst_n;
    logic init_done;
    int   checks;
    int   errors;
    rd_exp_t sb[$];

    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] sram_dout;

    dpram_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dpram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ZERO(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, old data on same-address collision.
    always_ff @(posedge clk) begin
        if (bus.mem_ren) sram_dout <= sram[bus.mem_raddr];
        if (bus.mem_wen) sram[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = sram_dout;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the read-return tags against the scoreboard.
    task automatic tick();
        rd_exp_t e;
        @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_valid_0", bus.rd_valid_0, (e.who == 1'b0) ? 32'd1 : 32'd0);
            chk("rd_valid_1", bus.rd_valid_1, (e.who == 1'b1) ? 32'd1 : 32'd0);
            chk("rd_data", bus.rd_data, e.data);
        end else begin
            chk("rd_valid_idle", {30'd0, bus.rd_valid_1, bus.rd_valid_0}, 32'd0);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < n; i++) tick();
        chk("rst_init_done", init_done, 32'd0);
        chk("rst_gnts", {28'd0, bus.wr_gnt_0, bus.wr_gnt_1, bus.rd_gnt_0, bus.rd_gnt_1}, 32'd0);
        chk("rst_mem_en", {30'd0, bus.mem_wen, bus.mem_ren}, 32'd0);
        chk("rst_no_x", {31'd0, $isunknown({bus.mem_waddr, bus.mem_wdata, bus.mem_raddr})}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Run n sweep cycles, optionally with all four requests asserted (dropped before RUN).
    task automatic init_run(input int n, input bit with_req);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            bus.wr_req_0 = with_req && (i != 1023);
            bus.wr_req_1 = with_req && (i != 1023);
            bus.rd_req_0 = with_req && (i != 1023);
            bus.rd_req_1 = with_req && (i != 1023);
            #1;
            if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== AW'(i) || bus.mem_wdata !== 32'd0 ||
                bus.mem_ren !== 1'b0 || init_done !== 1'b0 ||
                {bus.wr_gnt_0, bus.wr_gnt_1, bus.rd_gnt_0, bus.rd_gnt_1} !== 4'd0) bad++;
            tick();
        end
        chk("init_sweep_bad_cycles", bad, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.wr_req_0 = 1'b0; bus.wr_req_1 = 1'b0; bus.rd_req_0 = 1'b0; bus.rd_req_1 = 1'b0;
        bus.wr_addr_0 = '0; bus.wr_addr_1 = '0; bus.rd_addr_0 = '0; bus.rd_addr_1 = '0;
        bus.wr_data_0 = '0; bus.wr_data_1 = '0;

        @(posedge clk);
        #2;
        do_reset(2);

        // Full sweep with requests pending: no grants until init_done.
        init_run(1024, 1'b1);
        chk("init_done_at_1024", init_done, 32'd1);
        chk("run_idle_wen", bus.mem_wen, 32'd0);

        // Write contention from reset priority: 0,1,0,1.
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 10'h010; bus.wr_data_0 = 32'h0000_00A0;
        bus.wr_req_1 = 1'b1; bus.wr_addr_1 = 10'h020; bus.wr_data_1 = 32'h0000_00B1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wc_gnt0", bus.wr_gnt_0, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("wc_gnt1", bus.wr_gnt_1, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("wc_waddr", bus.mem_waddr, (k % 2 == 0) ? 32'h010 : 32'h020);
            chk("wc_wdata", bus.mem_wdata, (k % 2 == 0) ? 32'hA0 : 32'hB1);
            tick();
        end
        bus.wr_req_0 = 1'b0; bus.wr_req_1 = 1'b0;

        // Single writer then reader.
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 10'h155; bus.wr_data_0 = 32'hDEAD_BEEF;
        #1;
        chk("sw_gnt0", bus.wr_gnt_0, 32'd1);
        chk("sw_wen", bus.mem_wen, 32'd1);
        chk("sw_waddr", bus.mem_waddr, 32'h155);
        tick();
        bus.wr_req_0 = 1'b0;
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 10'h155;
        #1;
        chk("sr_gnt0", bus.rd_gnt_0, 32'd1);
        chk("sr_raddr", bus.mem_raddr, 32'h155);
        sb.push_back('{who: 1'b0, data: 32'hDEAD_BEEF});
        tick();
        bus.rd_req_0 = 1'b0;
        #1;
        tick();

        // Parallel ports on the same address: read sees old data.
        bus.wr_req_0 = 1'b1; bus.wr_addr_0 = 10'h005; bus.wr_data_0 = 32'h11;
        bus.rd_req_1 = 1'b1; bus.rd_addr_1 = 10'h005;
        #1;
        chk("pp_wgnt0", bus.wr_gnt_0, 32'd1);
        chk("pp_rgnt1", bus.rd_gnt_1, 32'd1);
        chk("pp_ren", bus.mem_ren, 32'd1);
        sb.push_back('{who: 1'b1, data: 32'h0});
        tick();
        bus.wr_req_0 = 1'b0;
        #1;
        chk("pp_rgnt1_again", bus.rd_gnt_1, 32'd1);
        sb.push_back('{who: 1'b1, data: 32'h11});
        tick();
        bus.rd_req_1 = 1'b0;

        // Unfair requests: req1 always, req0 every third cycle.
        bus.rd_addr_0 = 10'h010; bus.rd_addr_1 = 10'h020;
        for (int k = 0; k < 9; k++) begin
            bus.rd_req_0 = (k % 3 == 0);
            bus.rd_req_1 = 1'b1;
            #1;
            chk("uf_gnt0", bus.rd_gnt_0, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("uf_gnt1", bus.rd_gnt_1, (k % 3 == 0) ? 32'd0 : 32'd1);
            chk("uf_raddr", bus.mem_raddr, (k % 3 == 0) ? 32'h010 : 32'h020);
            if (k % 3 == 0) sb.push_back('{who: 1'b0, data: 32'hA0});
            else            sb.push_back('{who: 1'b1, data: 32'hB1});
            tick();
        end
        bus.rd_req_0 = 1'b0; bus.rd_req_1 = 1'b0;
        #1;
        tick();

        // Reset with a read grant pending: no rd_valid afterwards.
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 10'h155;
        #1;
        chk("pend_gnt0", bus.rd_gnt_0, 32'd1);
        do_reset(1);
        bus.rd_req_0 = 1'b0;

        // Reset at sweep cycle 500: sweep restarts at 0.
        init_run(500, 1'b0);
        do_reset(1);
        init_run(1024, 1'b0);
        chk("init_done_after_restart", init_done, 32'd1);

        // Zero-fill overwrote earlier data.
        bus.rd_req_0 = 1'b1; bus.rd_addr_0 = 10'h155;
        #1;
        chk("zf_gnt0", bus.rd_gnt_0, 32'd1);
        sb.push_back('{who: 1'b0, data: 32'h0});
        tick();
        bus.rd_req_0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_rr_arbiter.md
# dpram_rr_arbiter

Two-requester round-robin arbiter and initialiser for the 1024x32 dual-port SRAM macro used by the dpram wrapper. It sits between two client blocks and one dual_port_sram instance and owns the SRAM's write and read ports. After reset it zero-fills the whole array, then grants write and read ports independently so one write and one read can complete per cycle. Read data is returned with a per-requester valid tag.

## Interface
- ADDR_WIDTH, 10, SRAM address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, SRAM data width
- INIT_ZERO, 1, 1 = zero-fill sweep after reset; 0 = skip sweep

- clk  in  1  single clock, shared with the SRAM wclk/rclk
- rst_n  in  1  reset, synchronous, active-low
- init_done  out  1  high once the array is usable
- wr_req_0 / wr_req_1  in  1  write request per requester
- wr_addr_0 / wr_addr_1  in  ADDR_WIDTH  write address
- wr_data_0 / wr_data_1  in  DATA_WIDTH  write data
- wr_gnt_0 / wr_gnt_1  out  1  write grant (combinational)
- rd_req_0 / rd_req_1  in  1  read request per requester
- rd_addr_0 / rd_addr_1  in  ADDR_WIDTH  read address
- rd_gnt_0 / rd_gnt_1  out  1  read grant (combinational)
- rd_valid_0 / rd_valid_1  out  1  rd_data belongs to this requester
- rd_data  out  DATA_WIDTH  shared read data (= mem_rdata)
- mem_wen  out  1  to SRAM wen
- mem_waddr  out  ADDR_WIDTH  to SRAM waddr
- mem_wdata  out  DATA_WIDTH  to SRAM data_in
- mem_ren  out  1  to SRAM ren
- mem_raddr  out  ADDR_WIDTH  to SRAM raddr
- mem_rdata  in  DATA_WIDTH  from SRAM d_out

## Operation
- FSM states: INIT and RUN. Reset enters INIT if INIT_ZERO=1, else RUN.
- INIT:
  - Drives mem_wen=1, mem_waddr=init_cnt, mem_wdata=0, mem_ren=0.
  - init_cnt increments from 0 each cycle; all grants are 0.
  - When init_cnt = depth-1 the write completes and the next state is RUN.
- RUN: init_done=1. The write arbiter and read arbiter are independent and identical:
  - Handshake: the requester holds req/addr/data stable until it sees gnt. A transfer occurs in a cycle where req and gnt are both high. Dropping req without a grant is legal.
  - Grant is combinational. Only one requester asserting: it is granted. Both asserting: the requester holding priority is granted.
  - Priority pointer (one per arbiter) resets to requester 0. After any grant, priority moves to the non-granted requester. With no grant the pointer holds.
  - mem_wen = OR of write grants; mem_waddr/mem_wdata are muxed from the granted requester. mem_ren and mem_raddr are built the same way.
  - When idle, the address/data mux defaults to requester 0 values; the enable is 0.
- Read return:
  - rd_valid_k is registered and high exactly one cycle after a rd_gnt_k transfer.
  - rd_data passes mem_rdata straight through and is meaningful only while some rd_valid is high.
- Same-address read and write in the same cycle: the read returns the old data (the SRAM reads before it writes). No forwarding is done.

## Timing
- Reset (rst_n low at a clk edge):
  - init_done, all gnt, all rd_valid, mem_wen and mem_ren are 0.
  - init_cnt=0 and both priority pointers = 0.
  - Addresses and data are don't-care but must be driven (no X from the arbiter).
- INIT timing: call the first clk edge with rst_n high cycle 0. Zero-writes happen in cycles 0..depth-1 and init_done is high from cycle depth (1024 by default).
- INIT_ZERO=0: init_done is high in cycle 0 after reset release.
- Reset asserted mid-INIT or mid-RUN: takes effect at the next edge. The sweep restarts from address 0 and an in-flight read's rd_valid is suppressed.
- Throughput: 1 write + 1 read per cycle. Under constant two-way contention each requester gets every other grant.
- Read latency: grant cycle N, rd_valid/rd_data in cycle N+1.

## Test plan
- Init sweep: release reset with INIT_ZERO=1 -> mem_wen high for exactly 1024 cycles with waddr 0..1023 and wdata 0; init_done rises in cycle 1024; no grants before then.
- Single writer then reader: req0 writes 0xDEADBEEF to addr 0x155 -> wr_gnt_0 the same cycle. Next cycle req0 reads 0x155 -> rd_valid_0 one cycle later with rd_data=0xDEADBEEF, and rd_valid_1 stays 0.
- Write contention: both wr_req held high for 4 cycles from reset priority -> grants alternate 0,1,0,1, each waddr/wdata matching the granted requester.
- Parallel ports: req0 writes addr 5 with 0x11 while req1 reads addr 5 in the same cycle (addr 5 held 0x0) -> both granted, rd_valid_1 with rd_data=0x0; a later read of addr 5 returns 0x11.
- Reset mid-operation: assert rst_n low at init cycle 500 for one cycle -> sweep restarts at address 0 and init_done rises 1024 cycles after release. Repeat with a pending read grant -> no rd_valid after reset.
- Unfair-request check: req1 read held high continuously, req0 read pulsed every 3rd cycle -> req0 is granted in every cycle it requests, and req1 is granted in all other cycles.
